// File: rtl/chroma_sequencer_if.sv
// Bundle between the timing/colour-space stages and the sine LUT driver.
// master drives timing strobes and picture chroma; slave is the sequencer.
// Outputs are the LUT phase/amplitude plus burst and parity status.
interface chroma_sequencer_if;
  logic              enable;
  logic              line_start;
  logic              frame_start;
  logic              active;
  logic [4:0]        chroma_phase;
  logic signed [5:0] chroma_amp;
  logic [4:0]        phase;
  logic signed [5:0] amplitude;
  logic              burst_active;
  logic              pal_v_invert;

  modport master (
    output enable, line_start, frame_start, active, chroma_phase, chroma_amp,
    input  phase, amplitude, burst_active, pal_v_invert
  );

  modport slave (
    input  enable, line_start, frame_start, active, chroma_phase, chroma_amp,
    output phase, amplitude, burst_active, pal_v_invert
  );
endinterface

// File: rtl/chroma_sequencer.sv
// Subcarrier NCO + burst timing FSM + PAL parity; arbitrates burst vs picture chroma onto the sine LUT.
// Latency: outputs registered, one clk after the inputs/state they reflect.
// No backpressure: free-running, every cycle produces a LUT phase/amplitude.
module chroma_sequencer #(
  parameter logic [31:0] PHASE_INC            = 32'd396713491,
  parameter int          BURST_START          = 269,
  parameter int          BURST_LEN            = 108,
  parameter int          BURST_AMP            = 12,
  parameter bit          PAL_MODE             = 1'b1,
  parameter bit          PHASE_RESET_ON_FRAME = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  chroma_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  localparam logic [9:0]        START_LAST = 10'(BURST_START - 1);
  localparam logic [9:0]        LEN_LAST   = 10'(BURST_LEN - 1);
  localparam logic signed [5:0] AMP_BURST  = 6'(BURST_AMP);

  state_t            state, state_n;
  logic [9:0]        count, count_n;
  logic              parity, parity_n;
  logic [31:0]       acc;

  logic [4:0]        base;
  logic [4:0]        burst_off;
  logic signed [5:0] amp_clamped;
  logic [4:0]        phase_d;
  logic signed [5:0] amp_d;
  logic              burst_d;

  // NCO accumulator: free-running, optionally re-phased at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (bus.frame_start && PHASE_RESET_ON_FRAME) begin
      acc <= '0;
    end else begin
      acc <= acc + PHASE_INC;
    end
  end

  // Line sequencer state, burst counter and line parity registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      parity <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      parity <= parity_n;
    end
  end

  // Next-state: burst timing per line; line_start restarts from any state
  always_comb begin
    state_n  = state;
    count_n  = count;
    parity_n = parity;
    case (state)
      IDLE: ;
      WAIT: begin
        if (count == START_LAST) begin
          state_n = BURST;
          count_n = '0;
        end else begin
          count_n = count + 10'd1;
        end
      end
      BURST: begin
        if (count == LEN_LAST) begin
          state_n = DONE;
          count_n = '0;
        end else begin
          count_n = count + 10'd1;
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase
    if (bus.line_start) begin
      state_n  = WAIT;
      count_n  = '0;
      parity_n = ~parity;
    end
    // frame start pins parity to even, overriding a simultaneous toggle
    if (bus.frame_start) begin
      parity_n = 1'b0;
    end
  end

  // Arbitration: burst uses next state so burst cycles line up with the
  // edge that enters BURST; the whole decision is then registered
  always_comb begin
    base        = acc[31:27];
    burst_off   = PAL_MODE ? (parity_n ? 5'd20 : 5'd12) : 5'd16;
    amp_clamped = (bus.chroma_amp == -6'sd32) ? -6'sd31 : bus.chroma_amp;
    phase_d     = base;
    amp_d       = '0;
    burst_d     = 1'b0;
    if (bus.enable) begin
      if (state_n == BURST) begin
        burst_d = 1'b1;
        amp_d   = AMP_BURST;
        phase_d = base + burst_off;
      end else if (bus.active) begin
        amp_d   = amp_clamped;
        phase_d = base + bus.chroma_phase;
      end
    end
  end

  // Registered LUT drive and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.phase        <= '0;
      bus.amplitude    <= '0;
      bus.burst_active <= 1'b0;
      bus.pal_v_invert <= 1'b0;
    end else begin
      bus.phase        <= phase_d;
      bus.amplitude    <= amp_d;
      bus.burst_active <= burst_d;
      bus.pal_v_invert <= parity_n;
    end
  end

endmodule

// File: tb/tb_chroma_sequencer.sv
// Directed bench: two instances (PAL and fixed-phase) share stimulus.
// NCO increment is 2^27 so the LUT base phase advances by one per clock.
// Short burst window (start 4, length 3) keeps each line at 9 clocks.
module tb_chroma_sequencer;
  localparam logic [31:0] INC = 32'h0800_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, line_start = 1'b0, frame_start = 1'b0, active = 1'b0;
  logic [4:0] chroma_phase = '0;
  logic signed [5:0] chroma_amp = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] acc_m = '0;
  logic [4:0]  base_e;

  always #5 clk = ~clk;

  chroma_sequencer_if if_pal ();
  chroma_sequencer_if if_ntc ();

  assign if_pal.enable = enable;       assign if_ntc.enable = enable;
  assign if_pal.line_start = line_start; assign if_ntc.line_start = line_start;
  assign if_pal.frame_start = frame_start; assign if_ntc.frame_start = frame_start;
  assign if_pal.active = active;       assign if_ntc.active = active;
  assign if_pal.chroma_phase = chroma_phase; assign if_ntc.chroma_phase = chroma_phase;
  assign if_pal.chroma_amp = chroma_amp; assign if_ntc.chroma_amp = chroma_amp;

  chroma_sequencer #(.PHASE_INC(INC), .BURST_START(4), .BURST_LEN(3), .BURST_AMP(12),
                     .PAL_MODE(1'b1), .PHASE_RESET_ON_FRAME(1'b1))
    dut_pal (.clk(clk), .rst_n(rst_n), .bus(if_pal));

  chroma_sequencer #(.PHASE_INC(INC), .BURST_START(4), .BURST_LEN(3), .BURST_AMP(12),
                     .PAL_MODE(1'b0), .PHASE_RESET_ON_FRAME(1'b1))
    dut_ntc (.clk(clk), .rst_n(rst_n), .bus(if_ntc));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; base_e is the NCO base the DUT uses at that edge
  task automatic tick();
    base_e = acc_m[31:27];
    if (!rst_n || frame_start) acc_m = '0;
    else acc_m = acc_m + INC;
    @(posedge clk);
    #1;
  endtask

  task automatic check_tick(input string tag, input bit b, input int amp,
                            input int off_pal, input int off_ntc, input bit par);
    check({tag, ".burst_pal"}, int'(if_pal.burst_active), int'(b));
    check({tag, ".burst_ntc"}, int'(if_ntc.burst_active), int'(b));
    check({tag, ".amp_pal"}, int'(if_pal.amplitude), amp);
    check({tag, ".amp_ntc"}, int'(if_ntc.amplitude), amp);
    check({tag, ".ph_pal"}, int'(if_pal.phase), (int'(base_e) + off_pal) % 32);
    check({tag, ".ph_ntc"}, int'(if_ntc.phase), (int'(base_e) + off_ntc) % 32);
    check({tag, ".par_pal"}, int'(if_pal.pal_v_invert), int'(par));
    check({tag, ".par_ntc"}, int'(if_ntc.pal_v_invert), int'(par));
  endtask

  // One 9-clock line: line_start at tick 0, burst expected after ticks 4..6
  task automatic run_line(input string tag, input bit fs, input bit en, input bit act,
                          input logic signed [5:0] camp, input logic [4:0] cph,
                          input int exp_amp, input bit par);
    bit b;
    int amp, opal, ontc;
    enable = en; active = act; chroma_amp = camp; chroma_phase = cph;
    line_start = 1'b1; frame_start = fs;
    for (int i = 0; i < 9; i++) begin
      tick();
      line_start = 1'b0; frame_start = 1'b0;
      b = en && (i >= 4) && (i <= 6);
      if (b) begin
        amp = 12; opal = par ? 20 : 12; ontc = 16;
      end else if (en && act) begin
        amp = exp_amp; opal = int'(cph); ontc = int'(cph);
      end else begin
        amp = 0; opal = 0; ontc = 0;
      end
      check_tick($sformatf("%s[%0d]", tag, i), b, amp, opal, ontc, par);
    end
  endtask

  initial begin
    // Reset held with random inputs: all outputs stay zero
    for (int i = 0; i < 4; i++) begin
      enable = 1'($urandom); line_start = 1'($urandom); frame_start = 1'($urandom);
      active = 1'($urandom); chroma_phase = 5'($urandom); chroma_amp = 6'($urandom);
      tick();
      check("rst.phase", int'(if_pal.phase), 0);
      check("rst.amp", int'(if_pal.amplitude), 0);
      check("rst.burst", int'(if_pal.burst_active), 0);
      check("rst.par", int'(if_pal.pal_v_invert), 0);
      check("rst.phase_n", int'(if_ntc.phase), 0);
      check("rst.amp_n", int'(if_ntc.amplitude), 0);
    end
    enable = 1'b1; line_start = 1'b0; frame_start = 1'b0; active = 1'b0;
    chroma_phase = '0; chroma_amp = '0;
    rst_n = 1'b1;
    acc_m = '0;

    // NCO base counts 0..31 and wraps back to 0
    for (int k = 0; k < 34; k++) begin
      tick();
      check($sformatf("nco[%0d]", k), int'(if_pal.phase), k % 32);
      check($sformatf("nco_amp[%0d]", k), int'(if_pal.amplitude), 0);
    end

    // Frame start + three lines: parity 0,1,0,1; picture chroma on later lines
    run_line("l1", 1'b1, 1'b1, 1'b0, 6'sd0, 5'd0, 0, 1'b0);
    run_line("l2", 1'b0, 1'b1, 1'b0, 6'sd0, 5'd0, 0, 1'b1);
    run_line("l3", 1'b0, 1'b1, 1'b1, -6'sd32, 5'd5, -31, 1'b0);
    run_line("l4", 1'b0, 1'b1, 1'b1, 6'sd31, 5'd9, 31, 1'b1);

    // Mid-burst restart: burst after E4,E5 then line_start sampled at E6
    active = 1'b0; line_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      line_start = 1'b0;
      check_tick($sformatf("ab[%0d]", i), (i >= 4), (i >= 4) ? 12 : 0,
                 (i >= 4) ? 12 : 0, (i >= 4) ? 16 : 0, 1'b0);
    end
    run_line("restart", 1'b0, 1'b1, 1'b0, 6'sd0, 5'd0, 0, 1'b1);

    // Colour disabled for a whole line, then re-enabled
    run_line("dis", 1'b0, 1'b0, 1'b1, 6'sd20, 5'd3, 0, 1'b0);
    run_line("reen", 1'b0, 1'b1, 1'b0, 6'sd0, 5'd0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end
endmodule
